// File: rtl/l2_config_and_types.sv
// Shared types and helpers for the L2-side coherence blocks.
//   burst_e          : AXI AWBURST encoding (type 3 is reserved)
//   line_addr()      : aligns a byte address down to its cache-line base
//   INV_RANGE_*_DEF  : default bounds of the CPU's cacheable region
package l2_config_and_types;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [31:0] INV_RANGE_L_DEF = 32'h8000_0000;
    localparam logic [31:0] INV_RANGE_H_DEF = 32'h8FFF_FFFF;

    // lb must be a power of two.
    function automatic logic [31:0] line_addr(input logic [31:0] a, input logic [31:0] lb);
        return a & ~(lb - 32'd1);
    endfunction

endpackage

// File: rtl/inv_fifo.sv
// Registered-storage FIFO for pending line invalidations.
//   clk, rst_n        : clock, asynchronous active-low reset (empties the FIFO)
//   push_i / din_i    : write request and data (ignored while full, even on a pop)
//   pop_i             : remove head (ignored while empty)
//   dout_o            : head entry, 0 while empty
//   full_o / empty_o  : occupancy flags
module inv_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/inv_snoop_queue.sv
// Snoops a second AXI master's write-address channel and turns each accepted
// burst into one data-cache invalidation per touched line, queued for the core.
//   clk, rst                  : clock, asynchronous active-low reset
//   s_aw*                     : AW channel from the snooped master (valid/ready gated)
//   m_awvalid / m_awready     : AW valid/ready toward the interconnect
//   inv_valid/inv_addr/inv_ack: invalidation handshake to the core
//   busy                      : expansion in progress or invalidations pending
module inv_snoop_queue
    import l2_config_and_types::*;
#(
    parameter int          DEPTH   = 8,
    parameter int          LINE_W  = 4,
    parameter logic [31:0] RANGE_L = INV_RANGE_L_DEF,
    parameter logic [31:0] RANGE_H = INV_RANGE_H_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [7:0]  s_awlen,
    input  logic [2:0]  s_awsize,
    input  logic [1:0]  s_awburst,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic        inv_valid,
    output logic [31:0] inv_addr,
    input  logic        inv_ack,
    output logic        busy
);

    localparam logic [31:0] LB = 32'(4 * LINE_W);

    typedef enum logic {IDLE, EXPAND} state_e;

    state_e      state_q;
    logic [31:0] cur_q, cur_d;
    logic [31:0] last_q, last_d;

    logic [31:0] region, incr_end, wrap_base, wrap_end;
    logic [32:0] end33;
    logic [31:0] first_line, last_line;
    logic        hs, fifo_full, fifo_empty, in_range, push;

    assign hs = (state_q == IDLE) && s_awvalid && m_awready;

    // Burst footprint. The INCR end is formed in 33 bits and clamped so the
    // line walk can never wrap past the top of the address space.
    always_comb begin
        region     = (32'(s_awlen) + 32'd1) << s_awsize;
        end33      = {1'b0, s_awaddr} + {1'b0, region} - 33'd1;
        incr_end   = end33[32] ? 32'hFFFF_FFFF : end33[31:0];
        wrap_base  = s_awaddr & ~(region - 32'd1);
        wrap_end   = wrap_base + region - 32'd1;
        first_line = line_addr(s_awaddr, LB);
        last_line  = line_addr(incr_end, LB);
        case (burst_e'(s_awburst))
            BURST_FIXED: begin
                first_line = line_addr(s_awaddr, LB);
                last_line  = line_addr(s_awaddr, LB);
            end
            BURST_WRAP: begin
                first_line = line_addr(wrap_base, LB);
                last_line  = line_addr(wrap_end, LB);
            end
            default: begin
                first_line = line_addr(s_awaddr, LB);
                last_line  = line_addr(incr_end, LB);
            end
        endcase
    end

    assign in_range = (cur_q >= RANGE_L) && (cur_q <= RANGE_H);
    assign push     = (state_q == EXPAND) && !fifo_full && in_range;

    always_comb begin
        cur_d  = cur_q;
        last_d = last_q;
        if (hs) begin
            cur_d  = first_line;
            last_d = last_line;
        end else if (state_q == EXPAND && !fifo_full) begin
            cur_d = cur_q + LB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (hs) state_q <= EXPAND;
                EXPAND:  if (!fifo_full && cur_q == last_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Walk pointers are pure data; the state register decides when they matter.
    always_ff @(posedge clk) begin
        cur_q  <= cur_d;
        last_q <= last_d;
    end

    assign m_awvalid = (state_q == IDLE) && s_awvalid;
    assign s_awready = (state_q == IDLE) && m_awready;

    inv_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .din_i   (cur_q),
        .pop_i   (inv_ack),
        .dout_o  (inv_addr),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign inv_valid = !fifo_empty;
    assign busy      = (state_q == EXPAND) || !fifo_empty;

endmodule

// File: tb/tb_inv_snoop_queue.sv
module tb_inv_snoop_queue;

    localparam int          DEPTH = 4;
    localparam int          LBYTES = 16;
    localparam logic [31:0] RL = 32'h8000_0000;
    localparam logic [31:0] RH = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_awvalid, s_awready, m_awvalid, m_awready;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        inv_valid, inv_ack, busy;
    logic [31:0] inv_addr;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    bit acc = 1'b0;
    logic [31:0] exp_q[$];

    inv_snoop_queue #(
        .DEPTH   (DEPTH),
        .LINE_W  (4),
        .RANGE_L (RL),
        .RANGE_H (RH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awsize  (s_awsize),
        .s_awburst (s_awburst),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .inv_valid (inv_valid),
        .inv_addr  (inv_addr),
        .inv_ack   (inv_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte footprint of the burst, then every line it overlaps.
    function automatic void model_burst(input logic [31:0] a, input logic [7:0] len,
                                        input logic [2:0] sz, input logic [1:0] bt);
        longint unsigned bytes, lo, hi, ln;
        bytes = (longint'(len) + 1) << sz;
        if (bt == 2'd0) begin
            lo = a; hi = a;
        end else if (bt == 2'd2) begin
            lo = a - (a % bytes);
            hi = lo + bytes - 1;
        end else begin
            lo = a;
            hi = longint'(a) + bytes - 1;
            if (hi > 64'hFFFF_FFFF) hi = 64'hFFFF_FFFF;
        end
        for (ln = lo - (lo % LBYTES); ln <= hi; ln += LBYTES)
            if (ln >= RL && ln <= RH) exp_q.push_back(32'(ln));
    endfunction

    task automatic tick();
        @(negedge clk);
        if (busy) busy_cnt++;
        if (s_awvalid && s_awready) begin
            acc = 1'b1;
            model_burst(s_awaddr, s_awlen, s_awsize, s_awburst);
        end
        if (inv_valid && inv_ack) begin
            chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("inv_addr", inv_addr, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        s_awaddr = a; s_awlen = l; s_awsize = s; s_awburst = b; s_awvalid = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            tick();
        end
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int inv_seen;
        logic [31:0] a;
        logic [7:0]  l;
        logic [1:0]  b;

        rst = 1'b0; s_awvalid = 1'b0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
        s_awburst = '0; m_awready = 1'b1; inv_ack = 1'b0;
        #3;
        chk("rst_inv_valid", 32'(inv_valid), 32'd0);
        chk("rst_inv_addr", inv_addr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_awready", 32'(s_awready), 32'd1);
        chk("rst_m_awvalid", 32'(m_awvalid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;

        // INCR spanning three lines, ack held.
        inv_ack = 1'b1;
        aw(32'h8000_0004, 8'd7, 3'd2, 2'd1);
        #1;
        chk("incr_fwd_mvalid", 32'(m_awvalid), 32'd1);
        chk("incr_fwd_sready", 32'(s_awready), 32'd1);
        tick();
        s_awvalid = 1'b0;
        chk("incr_t1_valid", 32'(inv_valid), 32'd0);
        chk("incr_t1_busy", 32'(busy), 32'd1);
        chk("incr_t1_sready", 32'(s_awready), 32'd0);
        tick();
        chk("incr_t2_valid", 32'(inv_valid), 32'd1);
        chk("incr_t2_addr", inv_addr, 32'h8000_0000);
        drain("incr");

        // Out-of-range single beat: forwarded, nothing queued.
        aw(32'h0000_1000, 8'd0, 3'd2, 2'd1);
        #1;
        chk("oor_fwd_mvalid", 32'(m_awvalid), 32'd1);
        busy_cnt = 0;
        inv_seen = 0;
        tick();
        s_awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (inv_valid) inv_seen++;
            tick();
        end
        chk("oor_busy_cycles", 32'(busy_cnt), 32'd1);
        chk("oor_inv_seen", 32'(inv_seen), 32'd0);

        // Six lines into a four-entry FIFO with the core stalled.
        inv_ack = 1'b0;
        aw(32'h8000_0000, 8'd23, 3'd2, 2'd1);
        tick();
        s_awvalid = 1'b0;
        repeat (8) tick();
        chk("stall_valid", 32'(inv_valid), 32'd1);
        chk("stall_addr", inv_addr, 32'h8000_0000);
        chk("stall_busy", 32'(busy), 32'd1);
        aw(32'h8000_0200, 8'd0, 3'd2, 2'd1);
        #1;
        chk("stall_sready", 32'(s_awready), 32'd0);
        chk("stall_mvalid", 32'(m_awvalid), 32'd0);
        acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr_stable", inv_addr, 32'h8000_0000);
        end
        chk("stall_no_accept", 32'(acc), 32'd0);
        inv_ack = 1'b1;
        k = 0;
        while (k < 30 && !acc) begin
            tick();
            k++;
        end
        s_awvalid = 1'b0;
        chk("stall_accepted", 32'(acc), 32'd1);
        chk("stall_accept_cycles", 32'(k), 32'd4);
        drain("stall");

        // WRAP folds onto one line.
        aw(32'h8000_0038, 8'd3, 3'd2, 2'd2);
        busy_cnt = 0;
        tick();
        s_awvalid = 1'b0;
        drain("wrap");
        chk("wrap_busy_cycles", 32'(busy_cnt), 32'd2);

        // FIXED touches only the start line.
        aw(32'h8000_0104, 8'd15, 3'd2, 2'd0);
        busy_cnt = 0;
        tick();
        s_awvalid = 1'b0;
        drain("fixed");
        chk("fixed_busy_cycles", 32'(busy_cnt), 32'd2);

        // Lower range boundary: one line below, one at the base.
        aw(32'h7FFF_FFF8, 8'd3, 3'd2, 2'd1);
        tick();
        s_awvalid = 1'b0;
        drain("range_lo");

        // Top of the address space must not wrap to zero.
        aw(32'hFFFF_FFF8, 8'd7, 3'd2, 2'd1);
        busy_cnt = 0;
        tick();
        s_awvalid = 1'b0;
        drain("top");
        chk("top_busy_cycles", 32'(busy_cnt), 32'd2);
        chk("top_idle_sready", 32'(s_awready), 32'd1);

        // Reset while expanding with three entries queued.
        inv_ack = 1'b0;
        aw(32'h8000_0000, 8'd23, 3'd2, 2'd1);
        tick();
        s_awvalid = 1'b0;
        repeat (3) tick();
        chk("mid_valid", 32'(inv_valid), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_valid", 32'(inv_valid), 32'd0);
        chk("mid_rst_addr", inv_addr, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b1;
        inv_ack = 1'b1;
        aw(32'h8000_0500, 8'd3, 3'd2, 2'd1);
        #1;
        chk("post_rst_fwd", 32'(m_awvalid), 32'd1);
        tick();
        s_awvalid = 1'b0;
        drain("post_rst");

        // Randomized bursts with random back-pressure on both sides.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0:       a = 32'h8000_0000 + $urandom_range(0, 4095);
                1:       a = 32'h7FFF_FFC0 + $urandom_range(0, 127);
                default: a = 32'hFFFF_FF80 + $urandom_range(0, 127);
            endcase
            b = 2'($urandom_range(0, 3));
            if (b == 2'd2) l = 8'((1 << $urandom_range(1, 4)) - 1);
            else           l = 8'($urandom_range(0, 15));
            aw(a, l, 3'($urandom_range(0, 2)), b);
            acc = 1'b0;
            k = 0;
            while (k < 100 && !acc) begin
                inv_ack   = ($urandom_range(0, 3) != 0);
                m_awready = ($urandom_range(0, 1) != 0);
                #1;
                chk("rnd_gate", 32'(s_awready), 32'(m_awvalid && m_awready));
                tick();
                k++;
            end
            s_awvalid = 1'b0;
            chk("rnd_accepted", 32'(acc), 32'd1);
        end
        inv_ack = 1'b1;
        m_awready = 1'b1;
        drain("rnd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
